// File: rtl/send_pkg.sv
// Shared types and width helpers for the multilane send controller.
// Imported by the FIFO and the top-level serialiser.
package send_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned MIN_WORD_W = 2;
    localparam int unsigned MIN_DEPTH  = 2;

    // Counter width that stays legal when the range collapses to one value.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/send_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Level is one bit wider than the pointers so full and empty differ.
module send_fifo
    import send_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/multilane_send_controller.sv
// Multi-lane word serialiser with forwarded-clock gate and frame sync.
// Words stream back-to-back from the input FIFO with no idle gap.
module multilane_send_controller
    import send_pkg::*;
#(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned LANES       = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_PERIOD = 4,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W*LANES-1:0]       s_data,
    output logic [LANES-1:0]              data_out,
    output logic                          clk_en,
    output logic                          sync_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned NB  = WORD_W * LANES;
    localparam int unsigned BCW = cw(WORD_W);
    localparam int unsigned SCW = cw(SYNC_PERIOD);

    if (WORD_W < MIN_WORD_W) begin : g_chk_word
        $error("WORD_W must be >= 2");
    end
    if (LANES < 1) begin : g_chk_lanes
        $error("LANES must be >= 1");
    end
    if (FIFO_DEPTH < MIN_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (SYNC_PERIOD < 1) begin : g_chk_sync
        $error("SYNC_PERIOD must be >= 1");
    end

    state_e         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
    logic           sync_q, sync_d;
    logic           load, shift, clear, pop;
    logic           word_sync;
    logic           fifo_empty, fifo_full;
    logic [NB-1:0]  fifo_head;

    send_fifo #(
        .W     (NB),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s_valid),
        .data_i  (s_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign s_ready   = !fifo_full;
    assign clk_en    = (state_q == ST_SHIFT);
    assign sync_out  = sync_q;
    assign busy      = (state_q == ST_SHIFT) || (fifo_level != '0);
    assign word_sync = (sync_cnt_q == SCW'(SYNC_PERIOD - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        sync_d     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    bit_cnt_d = BCW'(WORD_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    // Last bit goes out on this edge: count the word.
                    if (bit_cnt_q == BCW'(1)) begin
                        sync_d     = word_sync;
                        sync_cnt_d = word_sync ? '0 : sync_cnt_q + 1'b1;
                    end
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    bit_cnt_d = BCW'(WORD_W - 1);
                end else begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            sync_q     <= sync_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] sh_q;
        logic              bit_q;

        assign word        = fifo_head[k*WORD_W +: WORD_W];
        assign data_out[k] = bit_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sh_q  <= '0;
                bit_q <= 1'b0;
            end else if (load) begin
                if (MSB_FIRST) begin
                    bit_q <= word[WORD_W-1];
                    sh_q  <= {word[WORD_W-2:0], 1'b0};
                end else begin
                    bit_q <= word[0];
                    sh_q  <= {1'b0, word[WORD_W-1:1]};
                end
            end else if (shift) begin
                if (MSB_FIRST) begin
                    bit_q <= sh_q[WORD_W-1];
                    sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
                end else begin
                    bit_q <= sh_q[0];
                    sh_q  <= {1'b0, sh_q[WORD_W-1:1]};
                end
            end else if (clear) begin
                bit_q <= 1'b0;
            end
        end
    end

endmodule
